// File: rtl/binary_pkg.sv
// Shared types and default widths for the binary counter sequencer.
package binary_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int LEN_W_DEF  = 8;
    localparam int NUM_W_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/binary_len_cnt.sv
// Loadable down-counter shared by the trig-high and trig-low phases.
module binary_len_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [LEN_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/binary_seq_ctrl.sv
// Burst sequencer for the 4-bit binary counter trig input, with wrap
// counting on the counter feedback and a busy/done handshake.
module binary_seq_ctrl
    import binary_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int NUM_W  = NUM_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  run_len,
    input  logic [LEN_W-1:0]  gap_len,
    input  logic [NUM_W-1:0]  burst_num,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              trig,
    output logic              busy,
    output logic              done,
    output logic [NUM_W-1:0]  burst_idx,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    logic               r_trig;
    logic               r_busy;
    logic               r_done;
    logic [NUM_W-1:0]   r_burst_idx;
    logic [WRAP_W-1:0]  r_wraps;
    logic [CNT_W-1:0]   r_prev_cnt;
    logic [LEN_W-1:0]   r_run_len;
    logic [LEN_W-1:0]   r_gap_len;
    logic [NUM_W-1:0]   r_burst_num;

    logic               w_accept;
    logic               w_empty;
    logic               w_last;
    logic               w_wrap;
    logic               w_load;
    logic               w_en;
    logic               w_zero;
    logic [LEN_W-1:0]   w_load_val;
    logic [NUM_W-1:0]   w_idx_nxt;

    assign w_accept  = start && !abort;
    assign w_empty   = (run_len == '0) || (burst_num == '0);
    assign w_idx_nxt = r_burst_idx + 1'b1;
    assign w_last    = (w_idx_nxt == r_burst_num);
    assign w_wrap    = r_busy && (r_prev_cnt == L_CNT_MAX) && (cnt_in == '0);

    // The length counter holds (remaining cycles - 1) of the current phase.
    always_comb begin
        w_load     = 1'b0;
        w_en       = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_empty) begin
                    w_load     = 1'b1;
                    w_load_val = run_len - 1'b1;
                end
            end
            ST_RUN: begin
                if (!abort) begin
                    if (w_zero && !w_last) begin
                        w_load     = 1'b1;
                        w_load_val = (r_gap_len == '0) ? (r_run_len - 1'b1)
                                                       : (r_gap_len - 1'b1);
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!abort) begin
                    if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = r_run_len - 1'b1;
                    end else begin
                        w_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    binary_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_burst_idx <= '0;
            r_wraps     <= '0;
            r_prev_cnt  <= '0;
            r_run_len   <= '0;
            r_gap_len   <= '0;
            r_burst_num <= '0;
        end else begin
            r_prev_cnt <= cnt_in;
            r_done     <= 1'b0;
            if (w_wrap && (r_wraps != '1)) begin
                r_wraps <= r_wraps + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_run_len   <= run_len;
                        r_gap_len   <= gap_len;
                        r_burst_num <= burst_num;
                        r_burst_idx <= '0;
                        r_wraps     <= '0;
                        r_busy      <= 1'b1;
                        if (w_empty) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_trig  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_trig  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        r_burst_idx <= w_idx_nxt;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_trig  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_gap_len != '0) begin
                            r_state <= ST_GAP;
                            r_trig  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_zero) begin
                        r_state <= ST_RUN;
                        r_trig  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign trig      = r_trig;
    assign busy      = r_busy;
    assign done      = r_done;
    assign burst_idx = r_burst_idx;
    assign wraps     = r_wraps;

endmodule

// File: tb/tb_binary_seq_ctrl.sv
// Bench for binary_seq_ctrl with a stand-in 4-bit trig counter on cnt_in.
module tb_binary_seq_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] run_len;
    logic [7:0] gap_len;
    logic [3:0] burst_num;
    logic       abort;
    logic [3:0] cnt_in;
    logic       trig;
    logic       busy;
    logic       done;
    logic [3:0] burst_idx;
    logic [7:0] wraps;

    int checks = 0;
    int errors = 0;

    binary_seq_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .run_len   (run_len),
        .gap_len   (gap_len),
        .burst_num (burst_num),
        .abort     (abort),
        .cnt_in    (cnt_in),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .burst_idx (burst_idx),
        .wraps     (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the binary counter: counts every cycle trig is high.
    logic [3:0] tb_cnt;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tb_cnt <= '0;
        else if (trig) tb_cnt <= tb_cnt + 1'b1;
    end
    assign cnt_in = tb_cnt;

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({trig, busy, done, burst_idx, wraps} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state got trig=%b busy=%b done=%b idx=%0d wraps=%0d want all 0",
                     trig, busy, done, burst_idx, wraps);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({trig, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle got trig=%b busy=%b done=%b want 000", trig, busy, done);
        end
    endtask

    // Expected trace: run_len highs per burst, gap_len lows between bursts,
    // then a one-cycle done, then idle. poke>=0 re-asserts start mid-sequence.
    task automatic test_sequence(input int rl, input int gl, input int bn,
                                 input int poke, input string nm);
        int exp_trig[$];
        int c0, tot, exp_idx, exp_wraps, exp_cnt;
        exp_trig.delete();
        if (rl > 0 && bn > 0) begin
            for (int b = 0; b < bn; b++) begin
                for (int i = 0; i < rl; i++) exp_trig.push_back(1);
                if (b < bn - 1)
                    for (int i = 0; i < gl; i++) exp_trig.push_back(0);
            end
        end
        c0        = int'(tb_cnt);
        tot       = (rl > 0 && bn > 0) ? rl * bn : 0;
        exp_idx   = (rl > 0 && bn > 0) ? bn : 0;
        exp_wraps = (c0 + tot) / 16;
        if (exp_wraps > 255) exp_wraps = 255;
        exp_cnt   = (c0 + tot) % 16;

        @(negedge clk);
        start = 1'b1; run_len = 8'(rl); gap_len = 8'(gl); burst_num = 4'(bn);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_trig.size(); i++) begin
            checks++;
            if (trig !== exp_trig[i][0] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d got trig=%b busy=%b done=%b want trig=%0d busy=1 done=0",
                         nm, i, trig, busy, done, exp_trig[i]);
            end
            if (i == poke) begin
                start = 1'b1; run_len = 8'(rl + 5); gap_len = 8'd0; burst_num = 4'(bn + 1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (trig !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle got trig=%b busy=%b done=%b want 0 1 1", nm, trig, busy, done);
        end
        @(negedge clk);
        checks++;
        if (trig !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done got trig=%b busy=%b done=%b want 0 0 0", nm, trig, busy, done);
        end
        checks++;
        if (int'(burst_idx) != exp_idx) begin
            errors++;
            $display("FAIL %s burst_idx got %0d want %0d", nm, burst_idx, exp_idx);
        end
        checks++;
        if (int'(wraps) != exp_wraps) begin
            errors++;
            $display("FAIL %s wraps got %0d want %0d", nm, wraps, exp_wraps);
        end
        checks++;
        if (int'(tb_cnt) != exp_cnt) begin
            errors++;
            $display("FAIL %s counter_out got %0d want %0d", nm, tb_cnt, exp_cnt);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; run_len = 8'd10; gap_len = 8'd2; burst_num = 4'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (trig !== 1'b1) begin
                errors++;
                $display("FAIL abort_run cycle %0d got trig=%b want 1", i, trig);
            end
            if (i == 3) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if (trig !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || burst_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_stop got trig=%b busy=%b done=%b idx=%0d want 0 0 0 0",
                     trig, busy, done, burst_idx);
        end
        // abort together with start in IDLE must not launch a sequence
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (trig !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle cycle %0d got trig=%b busy=%b done=%b want 0 0 0",
                         i, trig, busy, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_gap();
        @(negedge clk);
        start = 1'b1; run_len = 8'd2; gap_len = 8'd5; burst_num = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (trig !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_gap_pre got trig=%b busy=%b want 0 1", trig, busy);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({trig, busy, done, burst_idx, wraps} !== 15'd0) begin
            errors++;
            $display("FAIL rst_gap_async got trig=%b busy=%b done=%b idx=%0d wraps=%0d want all 0",
                     trig, busy, done, burst_idx, wraps);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 14; k++) begin
            int rl, gl, bn;
            rl = int'($urandom_range(0, 7));
            gl = int'($urandom_range(0, 4));
            bn = int'($urandom_range(0, 4));
            test_sequence(rl, gl, bn, -1, "random");
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        run_len = '0; gap_len = '0; burst_num = '0;
        test_reset();
        test_sequence(7, 3, 1, -1, "single");
        test_sequence(2, 3, 3, -1, "multi");
        do_reset();
        test_sequence(20, 0, 2, -1, "contig");
        test_sequence(0, 2, 5, -1, "zero_len");
        test_sequence(3, 2, 0, -1, "zero_num");
        test_abort();
        test_sequence(4, 1, 2, -1, "after_abort");
        test_sequence(3, 2, 2, 2, "start_ignored");
        test_reset_mid_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
